demux1x4_16_buf: RTL and testbench

Buffered 1-to-4 demultiplexer for 16-bit words: the distribution end of the 4x1 16-bit selection path. It accepts words from a single producer through a valid/ready handshake. Each accepted word is steered into one of four holding registers, and that register stays valid until its consumer acknowledges it. The block sits between a shared 16-bit source bus and four independent consumers, and counts accepted words for bench and debug visibility.

---
 rtl/demux1x4_16_buf_pkg.sv | 25 ++
 rtl/demux1x4_16_buf_chan.sv | 49 ++++
 rtl/demux1x4_16_buf.sv | 87 ++++++++
 tb/tb_demux1x4_16_buf.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/demux1x4_16_buf_pkg.sv
// demux1x4_16_buf_pkg
//   Shared constants and types for the buffered 1-to-4 word demultiplexer:
//   channel count, default word width, channel index type, channel state
//   encoding and a one-hot decode helper.
package demux1x4_16_buf_pkg;

    localparam int NCH   = 4;
    localparam int W_DEF = 16;

    typedef logic [1:0] ch_idx_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    // 2-to-4 destination decode.
    function automatic logic [NCH-1:0] dec_onehot(input ch_idx_t idx);
        logic [NCH-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/demux1x4_16_buf_chan.sv
// demux_chan
//   One output channel: a holding register plus its EMPTY/FULL flag.
//   Ports:
//     clk, rst : clock, async active-high reset
//     load     : capture din this edge (channel becomes/stays FULL)
//     ack      : consumer acknowledge; only acts while FULL
//     din      : word to capture
//     q        : held word (kept after consumption)
//     vld      : 1 while q holds an unconsumed word
module demux_chan
    import demux1x4_16_buf_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         ack,
    input  logic [W-1:0] din,
    output logic [W-1:0] q,
    output logic         vld
);

    chan_state_t state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Load wins over ack, so ack+load in one cycle keeps the channel FULL.
    // An ack while EMPTY falls through and is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (load) state_nxt = FULL;
            FULL:    if (!load && ack) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       q <= '0;
        else if (load) q <= din;
    end

    assign vld = (state == FULL);

endmodule

// File: rtl/demux1x4_16_buf.sv
// demux1x4_16_buf
//   Buffered 1-to-4 demultiplexer. A word accepted over the in_valid/in_ready
//   handshake is steered into one of four holding registers, which stay valid
//   until their consumer acks. Accepted words are counted modulo 2^16.
//   Build option: define DEMUX_RR_EN to take the destination from an internal
//   round-robin pointer instead of sel.
//   Ports:
//     clk, rst       : clock, async active-high reset
//     din, in_valid  : producer word and valid
//     in_ready       : destination can take a word (combinational on sel/ack)
//     sel            : destination channel (ignored with DEMUX_RR_EN)
//     o0..o3, vld    : channel holding registers and their valid flags
//     ack            : per-channel consumer acknowledge
//     ptr            : round-robin destination (0 without DEMUX_RR_EN)
//     cnt            : accepted word count
module demux1x4_16_buf
    import demux1x4_16_buf_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   din,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     sel,
    output logic [W-1:0]   o0,
    output logic [W-1:0]   o1,
    output logic [W-1:0]   o2,
    output logic [W-1:0]   o3,
    output logic [NCH-1:0] vld,
    input  logic [NCH-1:0] ack,
    output logic [1:0]     ptr,
    output logic [15:0]    cnt
);

    ch_idx_t                 dest;
    logic                    accept;
    logic [NCH-1:0]          load;
    logic [NCH-1:0][W-1:0]   dout;

`ifdef DEMUX_RR_EN
    ch_idx_t rr_ptr;
    logic    unused_sel;

    assign unused_sel = ^sel;

    // No skipping: a FULL channel at rr_ptr stalls the input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rr_ptr <= '0;
        else if (accept) rr_ptr <= rr_ptr + 2'd1;
    end

    assign dest = rr_ptr;
    assign ptr  = rr_ptr;
`else
    assign dest = sel;
    assign ptr  = '0;
`endif

    assign in_ready = !vld[dest] || ack[dest];
    assign accept   = in_valid && in_ready;
    assign load     = accept ? dec_onehot(dest) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         cnt <= '0;
        else if (accept) cnt <= cnt + 16'd1;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        demux_chan #(.W(W)) u_chan (
            .clk  (clk),
            .rst  (rst),
            .load (load[k]),
            .ack  (ack[k]),
            .din  (din),
            .q    (dout[k]),
            .vld  (vld[k])
        );
    end

    assign o0 = dout[0];
    assign o1 = dout[1];
    assign o2 = dout[2];
    assign o3 = dout[3];

endmodule

// File: tb/tb_demux1x4_16_buf.sv
module tb_demux1x4_16_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel;
    logic [15:0] o0, o1, o2, o3;
    logic [3:0]  vld;
    logic [3:0]  ack;
    logic [1:0]  ptr;
    logic [15:0] cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    demux1x4_16_buf #(.W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .o0       (o0),
        .o1       (o1),
        .o2       (o2),
        .o3       (o3),
        .vld      (vld),
        .ack      (ack),
        .ptr      (ptr),
        .cnt      (cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // advance one edge, settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // words used by the directed vectors
    logic [15:0] wsel [4] = '{16'd6234, 16'd725, 16'd7524, 16'd5734};
    logic [15:0] wrr  [8] = '{16'd65535, 16'd274, 16'd8224, 16'd2457,
                              16'd136, 16'd8564, 16'd24377, 16'd3548};

    initial begin
        rst = 1'b1; din = '0; in_valid = 1'b0; sel = '0; ack = '0;
        step(); step();
        chk("reset_vld",   vld,      4'b0000);
        chk("reset_cnt",   cnt,      16'd0);
        chk("reset_o0",    o0,       16'd0);
        chk("reset_o3",    o3,       16'd0);
        chk("reset_ptr",   ptr,      2'd0);
        rst = 1'b0;
        #1;
        chk("reset_ready", in_ready, 1'b1);

`ifndef DEMUX_RR_EN
        // selected mode, no acks: fill all four channels
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i); din = wsel[i]; in_valid = 1'b1;
            #1 chk("sel_fill_ready", in_ready, 1'b1);
            step();
        end
        in_valid = 1'b0;
        chk("sel_o0",  o0,  16'd6234);
        chk("sel_o1",  o1,  16'd725);
        chk("sel_o2",  o2,  16'd7524);
        chk("sel_o3",  o3,  16'd5734);
        chk("sel_vld", vld, 4'b1111);
        chk("sel_cnt", cnt, 16'd4);

        // full destination stalls
        sel = 2'd0; din = 16'd384; in_valid = 1'b1;
        #1 chk("stall_ready", in_ready, 1'b0);
        step();
        chk("stall_o0",  o0,  16'd6234);
        chk("stall_cnt", cnt, 16'd4);
        in_valid = 1'b0;

        // same-cycle ack and load on channel 2
        sel = 2'd2; din = 16'd9337; ack = 4'b0100; in_valid = 1'b1;
        #1 chk("ackload_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0; ack = 4'b0000;
        chk("ackload_o2",  o2,  16'd9337);
        chk("ackload_vld", vld, 4'b1111);
        chk("ackload_cnt", cnt, 16'd5);

        // plain ack on channel 3; data retained
        ack = 4'b1000;
        step();
        chk("ack3_vld", vld, 4'b0111);
        chk("ack3_o3",  o3,  16'd5734);
        // stray ack on emptied channel 3
        step();
        ack = 4'b0000;
        chk("stray3_vld", vld, 4'b0111);
        chk("stray3_cnt", cnt, 16'd5);
        chk("stray3_o3",  o3,  16'd5734);
        // refill channel 3 so all four are held before reset
        sel = 2'd3; din = 16'd1111; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("refill_vld", vld, 4'b1111);
`else
        // round-robin, consumers always ack
        ack = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            sel = 2'($urandom_range(0, 3)); din = wrr[i]; in_valid = 1'b1;
            #1;
            chk("rr_ready", in_ready, 1'b1);
            chk("rr_ptr",   ptr,      32'(i % 4));
            step();
        end
        in_valid = 1'b0;
        chk("rr_o0",  o0,  16'd136);
        chk("rr_o1",  o1,  16'd8564);
        chk("rr_o2",  o2,  16'd24377);
        chk("rr_o3",  o3,  16'd3548);
        chk("rr_cnt", cnt, 16'd8);
        chk("rr_ptr_wrap", ptr, 2'd0);
        step();
        chk("rr_drain_vld", vld, 4'b0000);

        // build ptr=1 with only channel 1 full
        ack = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            din = 16'(100 + i); in_valid = 1'b1;
            step();
        end
        ack = 4'b0001; din = 16'd104;
        step();
        in_valid = 1'b0; ack = 4'b1101;
        step();
        ack = 4'b0000;
        chk("rrst_setup_vld", vld, 4'b0010);
        chk("rrst_setup_ptr", ptr, 2'd1);

        din = 16'd4321; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("rrst_ready", in_ready, 1'b0);
            step();
            chk("rrst_ptr", ptr, 2'd1);
        end
        ack = 4'b0010;
        #1 chk("rrst_ack_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0; ack = 4'b0000;
        chk("rrst_ptr_adv", ptr, 2'd2);
        chk("rrst_o1",      o1,  16'd4321);
        chk("rrst_vld",     vld, 4'b0010);
        chk("rrst_cnt",     cnt, 16'd14);

        // fill all four (ptr 2,3,0 then 1 needs ack)
        ack = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            din = 16'(200 + i); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0; ack = 4'b0000;
        chk("refill_vld", vld, 4'b1111);
`endif

        // asynchronous reset mid-stream, visible before the next edge
        #2 rst = 1'b1;
        #1;
        chk("midrst_vld", vld, 4'b0000);
        chk("midrst_cnt", cnt, 16'd0);
        chk("midrst_o0",  o0,  16'd0);
        chk("midrst_o2",  o2,  16'd0);
        chk("midrst_ptr", ptr, 2'd0);
        step(); step();
        rst = 1'b0;

        // count wrap: 65535 accepts then one more
        ack = 4'b1111; sel = 2'd0; in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            din = 16'(i);
            step();
        end
        chk("wrap_pre_cnt", cnt, 16'd65535);
        din = 16'hBEEF;
        step();
        in_valid = 1'b0; ack = 4'b0000;
        chk("wrap_cnt", cnt, 16'd0);
`ifndef DEMUX_RR_EN
        chk("wrap_vld", vld, 4'b0001);
        chk("wrap_o0",  o0,  16'hBEEF);
        ack = 4'b1000;
        step();
        ack = 4'b0000;
        chk("stray_vld", vld, 4'b0001);
`else
        chk("wrap_vld", vld, 4'b1000);
        chk("wrap_o3",  o3,  16'hBEEF);
        ack = 4'b0001;
        step();
        ack = 4'b0000;
        chk("stray_vld", vld, 4'b1000);
`endif
        chk("stray_cnt", cnt, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
